// File: rtl/multi_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : multi_button_debounce
//  Description : N-channel active-low button debouncer with 2-flop input
//                synchronisers, press/release pulses and optional per-channel
//                toggle state (enabled by defining macro BTN_TOGGLE_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_button_debounce #(
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn_n,
    output logic [N_BTN-1:0] o_btn_down,
    output logic [N_BTN-1:0] o_btn_up,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_toggle
);

    localparam int                 c_CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEB_CYCLES - 1);

    logic [N_BTN-1:0] r_sync1_q, r_sync2_q;
    logic [N_BTN-1:0] w_sync1_d, w_sync2_d;
    logic [N_BTN-1:0] w_pressed;

    always_comb begin
        w_sync1_d = i_btn_n;
        w_sync2_d = r_sync1_q;
    end

    // Synchronisers reset to the released (high) raw level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1_q <= '1;
            r_sync2_q <= '1;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
        end
    end

    assign w_pressed = ~r_sync2_q;
    assign o_btn_up  = ~o_btn_down;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
        logic               r_stable_q, w_stable_d;
        logic               r_press_q, w_press_d;
        logic               r_release_q, w_release_d;

        // Any cycle where the synchronised level matches the stable state
        // restarts the count; acceptance happens on the DEB_CYCLES-th
        // consecutive differing cycle.
        always_comb begin
            w_cnt_d    = '0;
            w_stable_d = r_stable_q;
            if (w_pressed[i] != r_stable_q) begin
                if (r_cnt_q == c_CNT_MAX) begin
                    w_stable_d = w_pressed[i];
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            w_press_d   =  w_stable_d & ~r_stable_q;
            w_release_d = ~w_stable_d &  r_stable_q;
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_cnt_q     <= '0;
                r_stable_q  <= 1'b0;
                r_press_q   <= 1'b0;
                r_release_q <= 1'b0;
            end else begin
                r_cnt_q     <= w_cnt_d;
                r_stable_q  <= w_stable_d;
                r_press_q   <= w_press_d;
                r_release_q <= w_release_d;
            end
        end

        assign o_btn_down[i] = r_stable_q;
        assign o_press[i]    = r_press_q;
        assign o_release[i]  = r_release_q;

`ifdef BTN_TOGGLE_EN
        logic r_toggle_q, w_toggle_d;

        always_comb begin
            w_toggle_d = r_toggle_q ^ r_press_q;
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_toggle_q <= 1'b0;
            end else begin
                r_toggle_q <= w_toggle_d;
            end
        end

        assign o_toggle[i] = r_toggle_q;
`else
        assign o_toggle[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire
